// File: rtl/equiv_pkg.sv
// equiv_pkg: shared FSM state encoding and LFSR constants for equiv_check_sequencer
package equiv_pkg;
  typedef enum logic [2:0] {IDLE, APPLY, WAIT, CHECK, DONE} state_t;
  localparam logic [15:0] LFSR_TAPS = 16'hB400;
endpackage

// File: rtl/lfsr16.sv
// lfsr16: 16-bit right-shifting Galois LFSR; ports clk, rst_n, load (seed reload, wins over step), seed, step, q
module lfsr16
  import equiv_pkg::*;
#(
  parameter logic [15:0] SEED = 16'hACE1
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        load,
  input  logic [15:0] seed,
  input  logic        step,
  output logic [15:0] q
);
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) q <= SEED;
    else if (load) q <= seed;
    else if (step) q <= {1'b0, q[15:1]} ^ (q[0] ? LFSR_TAPS : 16'h0);
endmodule

// File: rtl/equiv_check_sequencer.sv
// equiv_check_sequencer: drives LFSR vectors into two implementations, compares after a settle delay, counts mismatches
// Ports: clk, rst_n, start, stop_on_err in; stim_o out to both DUTs; dut_a_i/dut_b_i responses in;
//        busy, done, pass, mismatch_cnt, err_valid, err_idx, err_a, err_b status out.
module equiv_check_sequencer
  import equiv_pkg::*;
#(
  parameter int          WIDTH   = 8,
  parameter int          NUM_VEC = 20000,
  parameter int          SETTLE  = 1,
  parameter logic [15:0] SEED    = 16'hACE1,
  parameter int          CNT_W   = 16
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             start,
  input  logic             stop_on_err,
  output logic [WIDTH-1:0] stim_o,
  input  logic [WIDTH-1:0] dut_a_i,
  input  logic [WIDTH-1:0] dut_b_i,
  output logic             busy,
  output logic             done,
  output logic             pass,
  output logic [CNT_W-1:0] mismatch_cnt,
  output logic             err_valid,
  output logic [CNT_W-1:0] err_idx,
  output logic [WIDTH-1:0] err_a,
  output logic [WIDTH-1:0] err_b
);
  state_t      state, state_n;
  logic [15:0] lfsr_q;
  logic [3:0]  wait_cnt;
  // Index kept at 32 bits so NUM_VEC is not limited by a narrow CNT_W; err_idx is a truncated copy.
  logic [31:0] vec_idx;
  logic        stop_lat, go, mis, last, lfsr_unused;
  assign busy        = state inside {APPLY, WAIT, CHECK};
  assign go          = start && !busy;
  assign mis         = dut_a_i != dut_b_i;
  assign last        = vec_idx == 32'(NUM_VEC - 1);
  assign lfsr_unused = ^lfsr_q;
  lfsr16 #(.SEED(SEED)) u_lfsr (
    .clk  (clk),
    .rst_n(rst_n),
    .load (go),
    .seed (SEED),
    .step (state == APPLY),
    .q    (lfsr_q)
  );
  always_comb begin
    state_n = state;
    unique case (state)
      IDLE, DONE: state_n = start ? APPLY : state;
      APPLY:      state_n = SETTLE == 0 ? CHECK : WAIT;
      WAIT:       state_n = wait_cnt <= 4'd1 ? CHECK : WAIT;
      CHECK:      state_n = last || (mis && stop_lat) ? DONE : APPLY;
      default:    state_n = IDLE;
    endcase
  end
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) state <= IDLE;
    else state <= state_n;
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) begin
      stim_o       <= '0;
      wait_cnt     <= '0;
      vec_idx      <= '0;
      stop_lat     <= 1'b0;
      done         <= 1'b0;
      pass         <= 1'b0;
      mismatch_cnt <= '0;
      err_valid    <= 1'b0;
      err_idx      <= '0;
      err_a        <= '0;
      err_b        <= '0;
    end else begin
      if (go) begin
        vec_idx      <= '0;
        stop_lat     <= stop_on_err;
        done         <= 1'b0;
        pass         <= 1'b0;
        mismatch_cnt <= '0;
        err_valid    <= 1'b0;
        err_idx      <= '0;
        err_a        <= '0;
        err_b        <= '0;
      end
      if (state == APPLY) begin
        stim_o   <= lfsr_q[WIDTH-1:0];
        wait_cnt <= 4'(SETTLE);
      end
      if (state == WAIT) wait_cnt <= wait_cnt - 4'd1;
      if (state == CHECK) begin
        if (mis) begin
          mismatch_cnt <= &mismatch_cnt ? mismatch_cnt : mismatch_cnt + CNT_W'(1);
          if (!err_valid) begin
            err_valid <= 1'b1;
            err_idx   <= CNT_W'(vec_idx);
            err_a     <= dut_a_i;
            err_b     <= dut_b_i;
          end
        end
        if (state_n == DONE) begin
          done <= 1'b1;
          pass <= mismatch_cnt == '0 && !mis;
        end else vec_idx <= vec_idx + 32'd1;
      end
    end
endmodule

// File: tb/tb_equiv_check_sequencer.sv
// tb_equiv_check_sequencer: scoreboard bench for equiv_check_sequencer across three parameter sets
module tb_equiv_check_sequencer;
  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;
  int n_chk = 0;
  int n_fail = 0;
  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask
  function automatic logic [7:0] rev8(input logic [7:0] x);
    logic [7:0] r;
    for (int i = 0; i < 8; i++) r[i] = x[7-i];
    return r;
  endfunction
  function automatic logic [15:0] lfsr_next(input logic [15:0] q);
    return {1'b0, q[15:1]} ^ (q[0] ? 16'hB400 : 16'h0);
  endfunction
  // main instance: NUM_VEC=16, SETTLE=1
  logic start0 = 1'b0, soe0 = 1'b0;
  logic [7:0] stim0, a0, b0, erra0, errb0;
  logic busy0, done0, pass0, ev0;
  logic [15:0] cnt0, eidx0;
  int fmode = 0;
  int cur_vec = 0;
  always_comb begin
    a0 = rev8(stim0);
    b0 = (fmode == 1 && cur_vec == 5) ? a0 ^ 8'h08 : (fmode == 2) ? a0 | 8'h01 : a0;
  end
  equiv_check_sequencer #(.WIDTH(8), .NUM_VEC(16), .SETTLE(1), .SEED(16'hACE1), .CNT_W(16)) u0 (
    .clk(clk), .rst_n(rst_n), .start(start0), .stop_on_err(soe0), .stim_o(stim0),
    .dut_a_i(a0), .dut_b_i(b0), .busy(busy0), .done(done0), .pass(pass0),
    .mismatch_cnt(cnt0), .err_valid(ev0), .err_idx(eidx0), .err_a(erra0), .err_b(errb0)
  );
  // SETTLE=0 instance
  logic start1 = 1'b0;
  logic [7:0] stim1, erra1, errb1;
  logic busy1, done1, pass1, ev1;
  logic [15:0] cnt1, eidx1;
  equiv_check_sequencer #(.WIDTH(8), .NUM_VEC(4), .SETTLE(0), .SEED(16'hACE1), .CNT_W(16)) u1 (
    .clk(clk), .rst_n(rst_n), .start(start1), .stop_on_err(1'b0), .stim_o(stim1),
    .dut_a_i(rev8(stim1)), .dut_b_i(rev8(stim1)), .busy(busy1), .done(done1), .pass(pass1),
    .mismatch_cnt(cnt1), .err_valid(ev1), .err_idx(eidx1), .err_a(erra1), .err_b(errb1)
  );
  // narrow counter instance, every vector mismatches
  logic start2 = 1'b0;
  logic [7:0] stim2, erra2, errb2;
  logic busy2, done2, pass2, ev2;
  logic [1:0] cnt2, eidx2;
  equiv_check_sequencer #(.WIDTH(8), .NUM_VEC(5), .SETTLE(1), .SEED(16'hACE1), .CNT_W(2)) u2 (
    .clk(clk), .rst_n(rst_n), .start(start2), .stop_on_err(1'b0), .stim_o(stim2),
    .dut_a_i(rev8(stim2)), .dut_b_i(~rev8(stim2)), .busy(busy2), .done(done2), .pass(pass2),
    .mismatch_cnt(cnt2), .err_valid(ev2), .err_idx(eidx2), .err_a(erra2), .err_b(errb2)
  );
  logic [7:0] stim_q[$];
  // mode 0: clean, 1: bit3 flipped on vector 5, 2: bit0 stuck-at-1
  task automatic run0(input int mode, input bit soe, input int rst_vec, input bit pulse_busy);
    logic [15:0] q;
    logic [7:0] s, a, b, ea, eb, hold;
    int cnt, idx, last, c;
    q = 16'hACE1; cnt = 0; idx = -1; last = 15; ea = 0; eb = 0;
    stim_q.delete();
    for (int v = 0; v < 16; v++) begin
      s = q[7:0]; q = lfsr_next(q); a = rev8(s);
      b = (mode == 1 && v == 5) ? a ^ 8'h08 : (mode == 2) ? a | 8'h01 : a;
      stim_q.push_back(s);
      if (a != b) begin
        cnt++;
        if (idx < 0) begin idx = v; ea = a; eb = b; end
        if (soe) begin last = v; break; end
      end
    end
    @(negedge clk); fmode = mode; cur_vec = 0; soe0 = soe; start0 = 1'b1;
    @(negedge clk); start0 = 1'b0;
    check("done_cleared", done0, 0);
    check("busy_on_start", busy0, 1);
    c = 0;
    while (!done0 && c < 200) begin
      cur_vec = c / 3;
      if (c == 1) check("stim_first_lit", stim0, 8'hE1);
      if (c % 3 == 1) begin
        if (stim_q.size() == 0) check("sb_underflow", 1, 0);
        else check($sformatf("stim_v%0d", c / 3), stim0, stim_q.pop_front());
      end
      if (rst_vec >= 0 && c == 3 * rst_vec) begin
        rst_n = 1'b0; #1;
        check("async_rst_outs", {busy0, done0, pass0, ev0, stim0, cnt0, eidx0}, 0);
        @(negedge clk); rst_n = 1'b1; stim_q.delete(); fmode = 0;
        return;
      end
      start0 = pulse_busy && c == 10;
      @(negedge clk); c++;
    end
    start0 = 1'b0;
    check("run_cycles", c, (last + 1) * 3);
    check("pass", pass0, cnt == 0);
    check("mismatch_cnt", cnt0, cnt);
    check("err_valid", ev0, idx >= 0);
    check("err_idx", eidx0, idx < 0 ? 0 : idx);
    check("err_a", erra0, ea);
    check("err_b", errb0, eb);
    check("sb_empty", stim_q.size(), 0);
    if (mode == 1) check("err_xor", erra0 ^ errb0, 8'h08);
    hold = stim0;
    repeat (6) @(negedge clk);
    check("idle_after_done", {busy0, done0, stim0}, {1'b0, 1'b1, hold});
  endtask
  initial begin
    int c;
    #1;
    check("reset_outs", {busy0, done0, pass0, ev0, stim0, cnt0, eidx0, erra0, errb0}, 0);
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
    check("idle_after_reset", {busy0, done0}, 0);
    run0(0, 1'b0, -1, 1'b0);
    run0(1, 1'b1, -1, 1'b0);
    run0(2, 1'b0, -1, 1'b0);
    run0(0, 1'b0, 7, 1'b0);
    run0(0, 1'b0, -1, 1'b0);
    run0(0, 1'b0, -1, 1'b1);
    @(negedge clk); start1 = 1'b1;
    @(negedge clk); start1 = 1'b0;
    c = 0;
    while (!done1 && c < 100) begin @(negedge clk); c++; end
    check("settle0_cycles", c, 8);
    check("settle0_pass", {pass1, cnt1}, {1'b1, 16'd0});
    @(negedge clk); start2 = 1'b1;
    @(negedge clk); start2 = 1'b0;
    c = 0;
    while (!done2 && c < 100) begin @(negedge clk); c++; end
    check("sat_cycles", c, 15);
    check("sat_cnt", cnt2, 3);
    check("sat_pass", pass2, 0);
    check("sat_err", {ev2, eidx2}, {1'b1, 2'd0});
    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end
  initial begin
    #2_000_000;
    $display("FAIL timeout: got running expected finished");
    $fatal(1);
  end
endmodule
